regfile_wb_ctrl: RTL and testbench

- Write-side master for the 32x32 register file.
- Accepts out-of-order completions from execute/memory units over a valid/ready handshake and buffers them in a small FIFO.
- Drains the FIFO one entry per cycle onto the register file write port (rd/regWrite/writeData).
- Keeps a per-register busy scoreboard so issue can detect RAW/WAW hazards against in-flight writes.

---
 rtl/rv_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 77 +++++++
 rtl/regfile_wb_ctrl.sv | 124 ++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the register-file write-back path.
//   XLEN      : width of a register value
//   AW        : register address width
//   NUM_REGS  : number of architectural registers (2**AW)
//   wb_entry_t: one pending register-file write (destination + result)
// ---------------------------------------------------------------------------
package rv_pkg;

  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage : rv_pkg

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of write-back entries with a fall-through head.
//   clk   in   clock
//   rst   in   synchronous active-low reset (empties the FIFO)
//   push  in   write din at the tail (ignored when full and not popping)
//   din   in   entry to enqueue
//   pop   in   drop the head entry (ignored when empty)
//   dout  out  current head entry (valid when !empty)
//   full  out  DEPTH entries held
//   empty out  no entries held
//   count out  current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  wb_entry_t                  din,
  input  logic                       pop,
  output wb_entry_t                  dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              do_push;
  logic              do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign count = count_reg;
  assign dout  = mem[rd_ptr_reg];

  // A full FIFO that is popping this cycle still has room for the push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage carries no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule : wb_fifo

// File: rtl/regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl
// Write-side master of the 32x32 register file. Buffers out-of-order
// completions in a FIFO, drains one per cycle onto the register-file write
// port and tracks in-flight destinations in a busy scoreboard.
//   clk        in   clock
//   rst        in   synchronous active-low reset
//   iss_valid  in   issue stage presents an instruction writing iss_rd
//   iss_rd     in   destination of the issuing instruction
//   iss_ready  out  issue allowed (no write already in flight to iss_rd)
//   q_rs1/2    in   sources of the instruction in decode
//   q_stall    out  a non-zero source is busy (RAW hazard)
//   cmp_valid  in   completion available
//   cmp_rd     in   completion destination (0 = accepted and dropped)
//   cmp_data   in   completion result
//   cmp_ready  out  completion can be accepted this cycle
//   rd         out  register-file write address (0 when idle)
//   regWrite   out  register-file write enable
//   writeData  out  register-file write data (0 when idle)
//   busy_vec   out  scoreboard, bit 0 always 0
//   fifo_count out  completion FIFO occupancy
// ---------------------------------------------------------------------------
module regfile_wb_ctrl
  import rv_pkg::*;
#(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int AW    = rv_pkg::AW,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_rd,
  output logic                    iss_ready,
  input  logic [AW-1:0]           q_rs1,
  input  logic [AW-1:0]           q_rs2,
  output logic                    q_stall,
  input  logic                    cmp_valid,
  input  logic [AW-1:0]           cmp_rd,
  input  logic [XLEN-1:0]         cmp_data,
  output logic                    cmp_ready,
  output logic [AW-1:0]           rd,
  output logic                    regWrite,
  output logic [XLEN-1:0]         writeData,
  output logic [NUM_REGS-1:0]     busy_vec,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  wb_entry_t              head;
  wb_entry_t              push_entry;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic                   iss_fire;
  logic                   retire_hit;
  logic [NUM_REGS-1:0]    busy_reg;
  logic [NUM_REGS-1:0]    busy_next;

  // ---------------- completion FIFO ----------------
  // The head drains every cycle it is valid. While reset is asserted the
  // drain is held off so a discarded completion never reaches the file.
  assign pop       = ~fifo_empty & rst;
  assign cmp_ready = ~fifo_full | pop;
  // rd=0 completions are handshaken but never stored.
  assign push      = cmp_valid & cmp_ready & (cmp_rd != '0);
  assign push_entry = '{rd: cmp_rd, data: cmp_data};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------- write port ----------------
  assign regWrite  = pop;
  assign rd        = fifo_empty ? '0 : head.rd;
  assign writeData = fifo_empty ? '0 : head.data;

  // ---------------- scoreboard ----------------
  // A register whose write is retiring this very edge is free for a new
  // issue; the set of the new issue then overrides the clear.
  assign retire_hit = pop & (head.rd == iss_rd);
  assign iss_ready  = ~busy_reg[iss_rd] | (iss_rd == '0) | retire_hit;
  assign iss_fire   = iss_valid & iss_ready & (iss_rd != '0);

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        logic set_bit;
        logic clr_bit;
        assign set_bit = iss_fire & (iss_rd == AW'(gi));
        assign clr_bit = pop & (head.rd == AW'(gi));
        assign busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_vec = busy_reg;

  // No forwarding from queued completions: a source stays stalled until its
  // write has actually retired.
  assign q_stall = ((q_rs1 != '0) & busy_reg[q_rs1]) |
                   ((q_rs2 != '0) & busy_reg[q_rs2]);

endmodule : regfile_wb_ctrl

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        q_stall;
  logic        cmp_valid;
  logic [4:0]  cmp_rd;
  logic [31:0] cmp_data;
  logic        cmp_ready;
  logic [4:0]  rd;
  logic        regWrite;
  logic [31:0] writeData;
  logic [31:0] busy_vec;
  logic [2:0]  fifo_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: set of busy registers and an ordered list of pending writes.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;
  ent_t q[$];
  bit   mbusy[32];
  int   pushes = 0;
  int   writes = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.XLEN(32), .AW(5), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_ready  (iss_ready),
    .q_rs1      (q_rs1),
    .q_rs2      (q_rs2),
    .q_stall    (q_stall),
    .cmp_valid  (cmp_valid),
    .cmp_rd     (cmp_rd),
    .cmp_data   (cmp_data),
    .cmp_ready  (cmp_ready),
    .rd         (rd),
    .regWrite   (regWrite),
    .writeData  (writeData),
    .busy_vec   (busy_vec),
    .fifo_count (fifo_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check every output against the model
  // half a cycle later, then advance the model across the edge.
  task automatic cyc(input bit en, input logic r,
                     input logic iv, input logic [4:0] ird,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic cv, input logic [4:0] crd, input logic [31:0] cd);
    bit          e_pop, e_cready, e_iready, e_stall;
    logic [4:0]  e_rd;
    logic [31:0] e_wd, e_busy;
    rst = r; iss_valid = iv; iss_rd = ird; q_rs1 = rs1; q_rs2 = rs2;
    cmp_valid = cv; cmp_rd = crd; cmp_data = cd;
    #4;
    e_pop    = r && (q.size() != 0);
    e_rd     = (q.size() != 0) ? q[0].rd : 5'd0;
    e_wd     = (q.size() != 0) ? q[0].data : 32'd0;
    e_cready = (q.size() < DEPTH) || e_pop;
    e_iready = (ird == 0) || !mbusy[ird] || (e_pop && q[0].rd == ird);
    e_stall  = (rs1 != 0 && mbusy[rs1]) || (rs2 != 0 && mbusy[rs2]);
    for (int i = 0; i < 32; i++) e_busy[i] = mbusy[i];
    if (en) begin
      chk("iss_ready",  64'(iss_ready),  64'(e_iready));
      chk("q_stall",    64'(q_stall),    64'(e_stall));
      chk("cmp_ready",  64'(cmp_ready),  64'(e_cready));
      chk("regWrite",   64'(regWrite),   64'(e_pop));
      chk("rd",         64'(rd),         64'(e_rd));
      chk("writeData",  64'(writeData),  64'(e_wd));
      chk("busy_vec",   64'(busy_vec),   64'(e_busy));
      chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    end
    if (e_pop) begin
      writes++;
      $display("[%0t] WB write rd=%0d data=%h", $time, e_rd, e_wd);
    end
    if (!r) begin
      q.delete();
      for (int i = 0; i < 32; i++) mbusy[i] = 0;
    end else begin
      if (e_pop) begin
        mbusy[q[0].rd] = 0;
        void'(q.pop_front());
      end
      if (iv && e_iready && ird != 0) mbusy[ird] = 1;
      if (cv && e_cready && crd != 0) begin
        q.push_back('{rd: crd, data: cd});
        pushes++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int          pick[$];
    int          cnt;
    logic [4:0]  crd;
    bit          cv;
    bit          inq[32];

    // Reset: first edge unchecked (state unknown), then checked under reset.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_busy",  64'(busy_vec),   64'h0);
    chk("reset_count", 64'(fifo_count), 64'h0);
    chk("reset_cmp_ready", 64'(cmp_ready), 64'h1);

    // Issue rd=1, observe RAW stall, then retire it.
    cyc(1, 1, 1, 5'd1, 0, 0, 0, 0, 0);
    chk("busy_after_iss1", 64'(busy_vec), 64'h2);
    cyc(1, 1, 0, 0, 5'd1, 0, 1, 5'd1, 32'hA5A5A5A5);
    chk("wb1_regWrite",  64'(regWrite),  64'h1);
    chk("wb1_rd",        64'(rd),        64'h1);
    chk("wb1_writeData", 64'(writeData), 64'hA5A5A5A5);
    cyc(1, 1, 0, 0, 5'd1, 0, 0, 0, 0);
    chk("busy_after_wb1", 64'(busy_vec), 64'h0);
    chk("stall_after_wb1", 64'(q_stall), 64'h0);

    // WAW on rd=3, then re-issue on the retiring edge.
    cyc(1, 1, 1, 5'd3, 0, 0, 0, 0, 0);
    chk("waw_blocked", 64'(iss_ready), 64'h0);
    cyc(1, 1, 1, 5'd3, 0, 0, 1, 5'd3, 32'h33333333);
    cyc(1, 1, 1, 5'd3, 0, 0, 0, 0, 0);   // head retiring 3 while re-issuing 3
    chk("reissue_busy3", 64'(busy_vec[3]), 64'h1);
    cyc(1, 1, 0, 0, 0, 0, 1, 5'd3, 32'h3A3A3A3A);
    idle(2);

    // Issue 1..5, then five back-to-back completions.
    for (int i = 1; i <= 5; i++) cyc(1, 1, 1, 5'(i), 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) cyc(1, 1, 0, 0, 0, 0, 1, 5'(i), 32'hC0DE0000 + 32'(i));
    idle(2);
    chk("drain_count", 64'(fifo_count), 64'h0);
    chk("drain_busy",  64'(busy_vec),   64'h0);

    // rd=0 completion is accepted and dropped.
    cyc(1, 1, 1, 5'd9, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
    chk("rd0_no_write", 64'(regWrite), 64'h0);
    chk("rd0_busy",     64'(busy_vec), 64'h200);
    cyc(1, 1, 0, 0, 0, 0, 1, 5'd9, 32'h99999999);
    idle(2);

    // Reset with completions in flight discards them.
    cyc(1, 1, 1, 5'd7, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 5'd8, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 5'd7, 32'h77777777);
    cyc(1, 1, 0, 0, 0, 0, 1, 5'd8, 32'h88888888);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_count", 64'(fifo_count), 64'h0);
    chk("rst_mid_busy",  64'(busy_vec),   64'h0);
    chk("rst_mid_regWrite", 64'(regWrite), 64'h0);
    idle(3);

    // Randomised traffic with only legal completions (plus rd=0 drops).
    cnt = 0;
    pushes = 0;
    while (pushes < 100 && cnt < 2000) begin
      for (int i = 0; i < 32; i++) inq[i] = 0;
      foreach (q[k]) inq[q[k].rd] = 1;
      pick.delete();
      for (int i = 1; i < 32; i++) if (mbusy[i] && !inq[i]) pick.push_back(i);
      cv  = 0;
      crd = 0;
      if ($urandom_range(0, 9) == 0) begin
        cv = 1;
      end else if (pick.size() != 0 && $urandom_range(0, 3) != 0) begin
        cv  = 1;
        crd = 5'(pick[$urandom_range(0, pick.size() - 1)]);
      end
      cyc(1, 1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          cv, crd, $urandom);
      cnt++;
    end
    chk("random_budget", 64'(pushes >= 100), 64'h1);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_wb_ctrl
